adjust_multi: RTL and testbench
===============================

Name: adjust_multi

Overview:
- Button-driven time/alarm editor; parametrised successor of the single-alarm adjust block.
- Sits between the debounced push-button inputs and the timekeeper/alarm comparators.
- Edits the current time plus NUM_ALARMS independent alarms, each as separate minute and hour fields.
- Adds wrap-safe BCD arithmetic, a timekeeper load handshake, and hold-to-repeat stepping.

Parameters:
- NUM_ALARMS, 2, number of alarm channels (1..4); field count F = 2 + 2*NUM_ALARMS.
- REPEAT_DELAY, 500, cycles a step button is held before auto-repeat starts.
- REPEAT_PERIOD, 100, cycles between repeated steps while held.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  edit mode enable; high = editing.
- btn  in  4  debounced buttons: [0] next field, [1] decrement, [2] previous field, [3] increment.
- cur_minunits  in  4  running-clock minute units (BCD).
- cur_mintens  in  3  running-clock minute tens.
- cur_hourunits  in  4  running-clock hour units.
- cur_hourtens  in  2  running-clock hour tens.
- minunits / mintens / hourunits / hourtens  out  4/3/4/2  edited time (BCD).
- load_time  out  1  one-cycle pulse: timekeeper loads edited time.
- alarm_minunits  out  4*NUM_ALARMS  packed, alarm k at [4k+3:4k].
- alarm_mintens  out  3*NUM_ALARMS  packed.
- alarm_hourunits  out  4*NUM_ALARMS  packed.
- alarm_hourtens  out  2*NUM_ALARMS  packed.
- sel  out  4  active field index, 0..F-1.
- led  out  F  one-hot field indicator.

Behaviour:
- Reset (async, rst high):
  - Edited time and all alarms = 00:00.
  - sel = 0, led = 0, load_time = 0, dirty = 0, repeat counter = 0.
- Field map:
  - sel 0 = time minutes; sel 1 = time hours.
  - sel 2+2k = alarm k minutes; sel 3+2k = alarm k hours.
- Button sampling:
  - btn is registered; actions trigger on the rising edge of exactly one bit.
  - Edges on two or more bits in the same cycle are ignored entirely (no step, no field move).
- Field select:
  - btn[0] edge: sel = (sel == F-1) ? 0 : sel+1.
  - btn[2] edge: sel = (sel == 0) ? F-1 : sel-1.
  - Moves are single-step only; no auto-repeat.
- Stepping (only while en = 1):
  - btn[3] increments, btn[1] decrements the selected field by 1.
  - Minutes are BCD 00..59 with wrap 59->00 and 00->59.
  - Hours are BCD 00..23 with wrap 23->00 and 00->23.
  - Units/tens carry and borrow are exact, e.g. 09->10, 10->09, 19->20, 20->19.
  - No intermediate illegal value (e.g. 24, 29) is ever visible on an output, even for one cycle.
  - A step on sel 0 or 1 sets dirty.
- en rising edge:
  - Edited time registers copy cur_* in that cycle; dirty cleared.
  - Alarm values are retained.
- en falling edge:
  - If dirty, load_time = 1 for exactly one cycle (the cycle after en is sampled low), then dirty cleared.
  - If not dirty, no pulse.
- en = 0:
  - Steps and field moves ignored; led = 0; sel holds its value.
  - Edited time outputs keep tracking cur_* every cycle.
- led:
  - While en = 1, led = one-hot(sel), registered; updates one cycle after sel changes.
- rst mid-edit: all state returns to reset values; no load_time pulse is generated.

Optional Feature:
- Macro ADJ_AUTOREPEAT_EN.
- Defined:
  - A step button held alone generates a step on the edge.
  - Another step after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles until released or a second bit asserts.
  - The counter restarts on a new edge.
- Undefined: exactly one step per press; repeat counter logic absent.

Test Plan:
- rst, en=1, sel=0, press btn[1] once -> minutes 59, hours 00, dirty set.
- Time 23:59, sel=1, press btn[3] -> hours 00, minutes unchanged 59; sel=1, btn[1] from 20 -> 19, never 1F or 29.
- NUM_ALARMS=2:
  - btn[0] pressed 5 times from sel 0 -> sel 5, led = 6'b100000; one more press -> sel 0.
  - btn[2] at sel 0 -> sel 5.
- cur = 14:07, raise en, increment minutes twice, drop en -> load_time high exactly one cycle with outputs 14:09; repeat without edits -> no pulse.
- btn = 4'b1010 edge (inc + dec together) -> no field change; btn[0]+btn[3] together -> nothing.
- ADJ_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4, hold btn[3] 30 cycles on minutes from 00 -> value 06 (steps at 0, 10, 14, 18, 22, 26); without the macro -> 01.

Source files
------------

// File: rtl/adjust_multi.sv
// Multi-field time/alarm editor with wrap-safe BCD stepping and load pulse.
// Optional hold-to-repeat stepping when ADJ_AUTOREPEAT_EN is defined.
module adjust_multi #(
  parameter int NUM_ALARMS    = 2,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [3:0]                btn,
  input  logic [3:0]                cur_minunits,
  input  logic [2:0]                cur_mintens,
  input  logic [3:0]                cur_hourunits,
  input  logic [1:0]                cur_hourtens,
  output logic [3:0]                minunits,
  output logic [2:0]                mintens,
  output logic [3:0]                hourunits,
  output logic [1:0]                hourtens,
  output logic                      load_time,
  output logic [4*NUM_ALARMS-1:0]   alarm_minunits,
  output logic [3*NUM_ALARMS-1:0]   alarm_mintens,
  output logic [4*NUM_ALARMS-1:0]   alarm_hourunits,
  output logic [2*NUM_ALARMS-1:0]   alarm_hourtens,
  output logic [3:0]                sel,
  output logic [2+2*NUM_ALARMS-1:0] led
);

  localparam int F = 2 + 2 * NUM_ALARMS;
  localparam logic [3:0] LAST = 4'(F - 1);

  function automatic logic [6:0] min_step(input logic [6:0] v,
                                          input logic up);
    logic [2:0] t;
    logic [3:0] u;
    {t, u} = v;
    if (up) begin
      if (u == 4'd9) begin
        u = 4'd0;
        t = (t == 3'd5) ? 3'd0 : t + 3'd1;
      end else u = u + 4'd1;
    end else begin
      if (u == 4'd0) begin
        u = 4'd9;
        t = (t == 3'd0) ? 3'd5 : t - 3'd1;
      end else u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [5:0] hour_step(input logic [5:0] v,
                                           input logic up);
    logic [1:0] t;
    logic [3:0] u;
    {t, u} = v;
    if (up) begin
      if (t == 2'd2 && u == 4'd3) begin
        t = 2'd0;
        u = 4'd0;
      end else if (u == 4'd9) begin
        u = 4'd0;
        t = t + 2'd1;
      end else u = u + 4'd1;
    end else begin
      if (t == 2'd0 && u == 4'd0) begin
        t = 2'd2;
        u = 4'd3;
      end else if (u == 4'd0) begin
        u = 4'd9;
        t = t - 2'd1;
      end else u = u - 4'd1;
    end
    return {t, u};
  endfunction

  logic [3:0] btn_q;
  logic [3:0] edges;
  logic       en_q;
  logic       dirty;
  logic       one_edge;
  logic       do_step;
  logic       up;
  logic       do_next;
  logic       do_prev;

  logic [NUM_ALARMS-1:0][3:0] amu;
  logic [NUM_ALARMS-1:0][2:0] amt;
  logic [NUM_ALARMS-1:0][3:0] ahu;
  logic [NUM_ALARMS-1:0][1:0] aht;

  assign alarm_minunits  = amu;
  assign alarm_mintens   = amt;
  assign alarm_hourunits = ahu;
  assign alarm_hourtens  = aht;

  assign edges    = btn & ~btn_q;
  assign one_edge = $onehot(edges);
  assign do_next  = en && one_edge && edges[0];
  assign do_prev  = en && one_edge && edges[2];

`ifdef ADJ_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0] rpt;
  logic          armed;
  logic          held;
  logic          fire;

  // Repeat only continues a press that began with a clean single edge.
  assign held = armed && (btn == btn_q) &&
                (btn == 4'b1000 || btn == 4'b0010);
  assign fire = held && (rpt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt   <= '0;
      armed <= 1'b0;
    end else if (one_edge && (edges[3] || edges[1])) begin
      rpt   <= RW'(REPEAT_DELAY - 1);
      armed <= 1'b1;
    end else if (held) begin
      rpt <= (rpt == '0) ? RW'(REPEAT_PERIOD - 1) : rpt - RW'(1);
    end else begin
      rpt   <= '0;
      armed <= 1'b0;
    end
  end

  assign do_step = en && en_q &&
                   ((one_edge && (edges[3] || edges[1])) || fire);
  assign up = one_edge ? edges[3] : btn[3];
`else
  assign do_step = en && en_q && one_edge && (edges[3] || edges[1]);
  assign up = edges[3];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= '0;
      en_q      <= 1'b0;
      dirty     <= 1'b0;
      load_time <= 1'b0;
      sel       <= '0;
      led       <= '0;
      minunits  <= '0;
      mintens   <= '0;
      hourunits <= '0;
      hourtens  <= '0;
      amu       <= '0;
      amt       <= '0;
      ahu       <= '0;
      aht       <= '0;
    end else begin
      btn_q     <= btn;
      en_q      <= en;
      load_time <= 1'b0;
      led       <= en ? F'(1) << sel : '0;
      if (en && !en_q) begin
        {mintens, minunits}   <= {cur_mintens, cur_minunits};
        {hourtens, hourunits} <= {cur_hourtens, cur_hourunits};
        dirty <= 1'b0;
      end else if (!en) begin
        if (en_q) begin
          load_time <= dirty;
          dirty     <= 1'b0;
        end
        // Hold the edited value through the load cycle.
        if (!(en_q && dirty)) begin
          {mintens, minunits}   <= {cur_mintens, cur_minunits};
          {hourtens, hourunits} <= {cur_hourtens, cur_hourunits};
        end
      end else if (do_step) begin
        if (sel == 4'd0) begin
          {mintens, minunits} <= min_step({mintens, minunits}, up);
          dirty <= 1'b1;
        end
        if (sel == 4'd1) begin
          {hourtens, hourunits} <= hour_step({hourtens, hourunits}, up);
          dirty <= 1'b1;
        end
        for (int k = 0; k < NUM_ALARMS; k++) begin
          if (sel == 4'(2 + 2 * k))
            {amt[k], amu[k]} <= min_step({amt[k], amu[k]}, up);
          if (sel == 4'(3 + 2 * k))
            {aht[k], ahu[k]} <= hour_step({aht[k], ahu[k]}, up);
        end
      end
      if (do_next)
        sel <= (sel == LAST) ? 4'd0 : sel + 4'd1;
      else if (do_prev)
        sel <= (sel == 4'd0) ? LAST : sel - 4'd1;
    end
  end

endmodule

// File: tb/tb_adjust_multi.sv
// Self-checking bench for adjust_multi: vector table, directed corners,
// and random presses against an arithmetic minutes/hours model.
module tb_adjust_multi;

  localparam int NA = 2;
  localparam int F  = 2 + 2 * NA;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [3:0] btn;
  logic [3:0] cur_minunits;
  logic [2:0] cur_mintens;
  logic [3:0] cur_hourunits;
  logic [1:0] cur_hourtens;
  logic [3:0] minunits;
  logic [2:0] mintens;
  logic [3:0] hourunits;
  logic [1:0] hourtens;
  logic       load_time;
  logic [4*NA-1:0] alarm_minunits;
  logic [3*NA-1:0] alarm_mintens;
  logic [4*NA-1:0] alarm_hourunits;
  logic [2*NA-1:0] alarm_hourtens;
  logic [3:0] sel;
  logic [F-1:0] led;

  adjust_multi #(
    .NUM_ALARMS(NA),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .btn(btn),
    .cur_minunits(cur_minunits),
    .cur_mintens(cur_mintens),
    .cur_hourunits(cur_hourunits),
    .cur_hourtens(cur_hourtens),
    .minunits(minunits),
    .mintens(mintens),
    .hourunits(hourunits),
    .hourtens(hourtens),
    .load_time(load_time),
    .alarm_minunits(alarm_minunits),
    .alarm_mintens(alarm_mintens),
    .alarm_hourunits(alarm_hourunits),
    .alarm_hourtens(alarm_hourtens),
    .sel(sel),
    .led(led)
  );

  always #5 clk = ~clk;

  int c_m = 0;
  int c_h = 0;
  assign cur_minunits  = 4'(c_m % 10);
  assign cur_mintens   = 3'(c_m / 10);
  assign cur_hourunits = 4'(c_h % 10);
  assign cur_hourtens  = 2'(c_h / 10);

  int errors = 0;
  int checks = 0;

  int m_sel = 0;
  int m_tm = 0;
  int m_th = 0;
  int m_am[NA];
  int m_ah[NA];

  bit mon_on = 1'b0;

  typedef struct {
    logic [3:0] b;
    int sel;
    int tm;
    int th;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  function automatic int act_tm();
    return int'(mintens) * 10 + int'(minunits);
  endfunction

  function automatic int act_th();
    return int'(hourtens) * 10 + int'(hourunits);
  endfunction

  function automatic int act_am(input int k);
    return int'(alarm_mintens[3*k +: 3]) * 10 +
           int'(alarm_minunits[4*k +: 4]);
  endfunction

  function automatic int act_ah(input int k);
    return int'(alarm_hourtens[2*k +: 2]) * 10 +
           int'(alarm_hourunits[4*k +: 4]);
  endfunction

  function automatic bit legal_m(input logic [2:0] t, input logic [3:0] u);
    return (t <= 3'd5) && (u <= 4'd9);
  endfunction

  function automatic bit legal_h(input logic [1:0] t, input logic [3:0] u);
    return (u <= 4'd9) && (t < 2'd2 || (t == 2'd2 && u <= 4'd3));
  endfunction

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      bit ok;
      ok = legal_m(mintens, minunits) && legal_h(hourtens, hourunits);
      for (int k = 0; k < NA; k++)
        ok = ok && legal_m(alarm_mintens[3*k +: 3], alarm_minunits[4*k +: 4])
                && legal_h(alarm_hourtens[2*k +: 2], alarm_hourunits[4*k +: 4]);
      chk("bcd_legal", int'(ok), 1);
    end
  end

  task automatic model_step(input int d);
    int k;
    if (m_sel == 0) m_tm = (m_tm + d + 60) % 60;
    else if (m_sel == 1) m_th = (m_th + d + 24) % 24;
    else begin
      k = (m_sel - 2) / 2;
      if (m_sel % 2 == 0) m_am[k] = (m_am[k] + d + 60) % 60;
      else m_ah[k] = (m_ah[k] + d + 24) % 24;
    end
  endtask

  task automatic model_apply(input logic [3:0] b);
    if (!en || $countones(b) != 1) return;
    if (b[0]) m_sel = (m_sel + 1) % F;
    if (b[2]) m_sel = (m_sel + F - 1) % F;
    if (b[3]) model_step(1);
    if (b[1]) model_step(-1);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    cycle();
    btn = 4'b0000;
    cycle();
    model_apply(b);
  endtask

  task automatic set_en(input logic v);
    en = v;
    cycle();
    if (v) begin
      m_tm = c_m;
      m_th = c_h;
    end
  endtask

  task automatic check_all(input string n);
    chk({n, "_min"}, act_tm(), en ? m_tm : c_m);
    chk({n, "_hour"}, act_th(), en ? m_th : c_h);
    chk({n, "_sel"}, int'(sel), m_sel);
    chk({n, "_led"}, int'(led), en ? (1 << m_sel) : 0);
    for (int k = 0; k < NA; k++) begin
      chk({n, "_amin"}, act_am(k), m_am[k]);
      chk({n, "_ahour"}, act_ah(k), m_ah[k]);
    end
  endtask

  initial begin
    int pulses;
    logic [3:0] b;
    int r;
    rst = 1'b1;
    en  = 1'b0;
    btn = 4'b0000;
    foreach (m_am[k]) begin
      m_am[k] = 0;
      m_ah[k] = 0;
    end

    tbl[0]  = '{4'b0010, 0, 59, 0};
    tbl[1]  = '{4'b1000, 0, 0, 0};
    tbl[2]  = '{4'b0010, 0, 59, 0};
    tbl[3]  = '{4'b0001, 1, 59, 0};
    tbl[4]  = '{4'b0010, 1, 59, 23};
    tbl[5]  = '{4'b1000, 1, 59, 0};
    tbl[6]  = '{4'b1010, 1, 59, 0};
    tbl[7]  = '{4'b1001, 1, 59, 0};
    tbl[8]  = '{4'b0100, 0, 59, 0};
    tbl[9]  = '{4'b0100, 5, 59, 0};
    tbl[10] = '{4'b0001, 0, 59, 0};
    tbl[11] = '{4'b0101, 0, 59, 0};

    repeat (3) cycle();
    chk("rst_sel", int'(sel), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_load", int'(load_time), 0);
    chk("rst_min", act_tm(), 0);
    chk("rst_hour", act_th(), 0);
    chk("rst_alarm", act_am(1) + act_ah(1), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    cycle();

    set_en(1'b1);
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].b);
      chk($sformatf("tbl%0d_sel", i), int'(sel), tbl[i].sel);
      chk($sformatf("tbl%0d_min", i), act_tm(), tbl[i].tm);
      chk($sformatf("tbl%0d_hour", i), act_th(), tbl[i].th);
    end

    for (int i = 0; i < 5; i++) press(4'b0001);
    chk("next5_sel", int'(sel), 5);
    chk("next5_led", int'(led), 32);
    press(4'b0001);
    chk("next6_sel", int'(sel), 0);
    press(4'b0100);
    chk("prev_wrap_sel", int'(sel), 5);
    press(4'b0001);

    set_en(1'b0);
    c_m = 59;
    c_h = 23;
    set_en(1'b1);
    press(4'b0001);
    press(4'b1000);
    chk("h23_inc_hour", act_th(), 0);
    chk("h23_inc_min", act_tm(), 59);
    check_all("h23");
    set_en(1'b0);
    c_m = 0;
    c_h = 20;
    set_en(1'b1);
    press(4'b0010);
    chk("h20_dec_hour", act_th(), 19);

    set_en(1'b0);
    c_m = 7;
    c_h = 14;
    set_en(1'b1);
    press(4'b0100);
    press(4'b1000);
    press(4'b1000);
    check_all("edit1409");
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (load_time) begin
        pulses++;
        chk("load_min", act_tm(), 9);
        chk("load_hour", act_th(), 14);
      end
    end
    chk("load_pulses", pulses, 1);
    check_all("after_load");
    set_en(1'b1);
    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (load_time) pulses++;
    end
    chk("clean_pulses", pulses, 0);

    c_m = 0;
    set_en(1'b1);
    btn = 4'b1000;
    repeat (30) cycle();
    btn = 4'b0000;
    cycle();
    cycle();
`ifdef ADJ_AUTOREPEAT_EN
    m_tm = 6;
`else
    m_tm = 1;
`endif
    chk("hold_min", act_tm(), m_tm);
    check_all("hold");

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) b = 4'(1 << (r % 4));
      else b = 4'($urandom_range(0, 15));
      press(b);
      check_all($sformatf("rnd%0d", i));
    end

    for (int i = 0; i < F && m_sel != 0; i++) press(4'b0100);
    press(4'b1000);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_led", int'(led), 0);
    chk("mid_rst_load", int'(load_time), 0);
    chk("mid_rst_min", act_tm(), 0);
    chk("mid_rst_hour", act_th(), 0);
    chk("mid_rst_alarm", act_am(0) + act_ah(0) + act_am(1), 0);
    en = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (load_time) pulses++;
    end
    chk("mid_rst_pulses", pulses, 0);
    m_sel = 0;
    foreach (m_am[k]) begin
      m_am[k] = 0;
      m_ah[k] = 0;
    end
    check_all("post_rst");

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
